// File: rtl/kernel_reg_file_if.sv
// Kernel register file bus: loader write port, commit/start controls and the weight stream to the MAC array.
interface kernel_reg_file_if #(
  parameter int KERNEL_REG_ADDR_WIDTH = 5,
  parameter int WEIGHT_WIDTH          = 8
);
  logic                             i_wr_en;
  logic [KERNEL_REG_ADDR_WIDTH-1:0] i_wr_addr;
  logic [WEIGHT_WIDTH-1:0]          i_wr_data;
  logic                             i_load_done;
  logic [5:0]                       i_kernel_size;
  logic                             i_rd_start;
  logic                             i_rd_ready;
  logic                             i_err_clr;
  logic                             o_rd_valid;
  logic [WEIGHT_WIDTH-1:0]          o_rd_data;
  logic [KERNEL_REG_ADDR_WIDTH-1:0] o_rd_addr;
  logic                             o_rd_last;
  logic                             o_kernel_ready;
  logic                             o_busy;
  logic                             o_wr_err;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_load_done, i_kernel_size,
           i_rd_start, i_rd_ready, i_err_clr,
    input  o_rd_valid, o_rd_data, o_rd_addr, o_rd_last, o_kernel_ready, o_busy, o_wr_err
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_load_done, i_kernel_size,
           i_rd_start, i_rd_ready, i_err_clr,
    output o_rd_valid, o_rd_data, o_rd_addr, o_rd_last, o_kernel_ready, o_busy, o_wr_err
  );
endinterface

// File: rtl/kernel_reg_file.sv
// Kernel weight store: captures loader writes and replays the committed kernel as a valid/ready stream.
// Define KERNEL_DBUF_EN for a double-buffered store (shadow writes, bank swap on commit).
module kernel_reg_file #(
  parameter int KERNEL_REG_ADDR_WIDTH = 5,
  parameter int KERNEL_DEPTH          = 25,
  parameter int WEIGHT_WIDTH          = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  kernel_reg_file_if.slave bus
);
  localparam int AW = KERNEL_REG_ADDR_WIDTH;
  localparam int WW = WEIGHT_WIDTH;
`ifdef KERNEL_DBUF_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif
  localparam logic [AW-1:0] IDX_ZERO = '0;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [WW-1:0]   mem_r [NUM_BANKS][KERNEL_DEPTH];
  logic [AW-1:0]   rd_idx_r;
  logic [AW-1:0]   last_idx_r;
  logic [WW-1:0]   rd_data_r;
  logic            rd_valid_r;
  logic            rd_last_r;
  logic            busy_r;
  logic            kernel_ready_r;
  logic            wr_err_r;

  logic            addr_ok_s;
  logic            size_ok_s;
  logic            start_ok_s;
  logic            xfer_s;
  logic            last_xfer_s;
  logic            advance_s;
  logic            wr_accept_s;
  logic            wr_drop_s;
  logic            wr_unready_s;
  logic            act_bank_s;
  logic            wr_bank_s;
  logic            first_bank_s;
  logic [AW-1:0]   next_idx_s;

`ifdef KERNEL_DBUF_EN
  logic            bank_r;
  logic            swap_pending_r;
`endif

  // Per-cycle decode of write legality, handshake and bank selection
  always_comb begin
    addr_ok_s   = ({1'b0, bus.i_wr_addr} < (AW+1)'(KERNEL_DEPTH));
    size_ok_s   = (bus.i_kernel_size != 6'd0) &&
                  ({26'd0, bus.i_kernel_size} <= 32'(KERNEL_DEPTH));
    start_ok_s  = (state_r == ST_IDLE) && bus.i_rd_start && kernel_ready_r && size_ok_s;
    xfer_s      = rd_valid_r && bus.i_rd_ready;
    last_xfer_s = xfer_s && rd_last_r;
    advance_s   = xfer_s && !rd_last_r;
    next_idx_s  = rd_idx_r + AW'(1);
`ifdef KERNEL_DBUF_EN
    wr_accept_s  = bus.i_wr_en && addr_ok_s;
    wr_drop_s    = bus.i_wr_en && !addr_ok_s;
    wr_unready_s = 1'b0;
    act_bank_s   = bank_r;
    wr_bank_s    = ~bank_r;
    // a commit in IDLE swaps at this edge, so a same-cycle start must fetch from the new bank
    first_bank_s = (bus.i_load_done && (state_r == ST_IDLE)) ? ~bank_r : bank_r;
`else
    wr_accept_s  = bus.i_wr_en && addr_ok_s && (state_r == ST_IDLE);
    wr_drop_s    = bus.i_wr_en && (!addr_ok_s || (state_r == ST_STREAM));
    wr_unready_s = wr_accept_s;
    act_bank_s   = 1'b0;
    wr_bank_s    = 1'b0;
    first_bank_s = 1'b0;
`endif
  end

  // Next-state logic for the stream FSM
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_next_s = ST_STREAM;
        else            state_next_s = ST_IDLE;
      end
      ST_STREAM: begin
        if (last_xfer_s) state_next_s = ST_IDLE;
        else             state_next_s = ST_STREAM;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= ST_IDLE;
    else          state_r <= state_next_s;
  end

  // Weight storage, cleared by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int e = 0; e < KERNEL_DEPTH; e++) begin
          mem_r[b][e] <= '0;
        end
      end
    end else if (wr_accept_s) begin
      mem_r[wr_bank_s][bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  // Stream beat registers: data/addr/last are loaded ahead so they hold steady while ready is low
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      rd_last_r  <= 1'b0;
      rd_idx_r   <= '0;
      last_idx_r <= '0;
      rd_data_r  <= '0;
    end else begin
      rd_valid_r <= (state_next_s == ST_STREAM);
      busy_r     <= (state_next_s == ST_STREAM);
      if (start_ok_s) begin
        rd_idx_r   <= '0;
        last_idx_r <= AW'(bus.i_kernel_size - 6'd1);
        rd_last_r  <= (bus.i_kernel_size == 6'd1);
        rd_data_r  <= mem_r[first_bank_s][IDX_ZERO];
      end else if (advance_s) begin
        rd_idx_r   <= next_idx_s;
        rd_last_r  <= (next_idx_s == last_idx_r);
        rd_data_r  <= mem_r[act_bank_s][next_idx_s];
      end
    end
  end

  // Commit flag and sticky illegal-write flag (set beats clear)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      kernel_ready_r <= 1'b0;
      wr_err_r       <= 1'b0;
    end else begin
      if (bus.i_load_done)   kernel_ready_r <= 1'b1;
      else if (wr_unready_s) kernel_ready_r <= 1'b0;
      if (wr_drop_s)          wr_err_r <= 1'b1;
      else if (bus.i_err_clr) wr_err_r <= 1'b0;
    end
  end

`ifdef KERNEL_DBUF_EN
  // Bank swap: immediate in IDLE, otherwise deferred to the edge the final beat transfers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bank_r         <= 1'b0;
      swap_pending_r <= 1'b0;
    end else if (bus.i_load_done && (state_r == ST_IDLE)) begin
      bank_r         <= ~bank_r;
    end else if (bus.i_load_done && last_xfer_s) begin
      bank_r         <= ~bank_r;
      swap_pending_r <= 1'b0;
    end else if (bus.i_load_done) begin
      swap_pending_r <= 1'b1;
    end else if (last_xfer_s && swap_pending_r) begin
      bank_r         <= ~bank_r;
      swap_pending_r <= 1'b0;
    end
  end
`endif

  assign bus.o_rd_valid     = rd_valid_r;
  assign bus.o_rd_data      = rd_data_r;
  assign bus.o_rd_addr      = rd_idx_r;
  assign bus.o_rd_last      = rd_last_r;
  assign bus.o_kernel_ready = kernel_ready_r;
  assign bus.o_busy         = busy_r;
  assign bus.o_wr_err       = wr_err_r;
endmodule

// File: tb/tb_kernel_reg_file.sv
// Randomized self-checking bench for kernel_reg_file against a bank/array reference model.
module tb_kernel_reg_file;
  localparam int AW    = 5;
  localparam int DEPTH = 25;
  localparam int WW    = 8;
`ifdef KERNEL_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  kernel_reg_file_if #(.KERNEL_REG_ADDR_WIDTH(AW), .WEIGHT_WIDTH(WW)) kif ();

  kernel_reg_file #(
    .KERNEL_REG_ADDR_WIDTH(AW),
    .KERNEL_DEPTH(DEPTH),
    .WEIGHT_WIDTH(WW)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (kif)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // reference model: two banks of weights, active bank index, commit/error flags
  logic [7:0] ref_mem [2][DEPTH];
  int         ref_act;
  bit         ref_ready;
  bit         ref_err;
  bit         ref_pending;
  bit         ref_streaming;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int b = 0; b < 2; b++)
      for (int e = 0; e < DEPTH; e++) ref_mem[b][e] = 8'd0;
    ref_act       = 0;
    ref_ready     = 1'b0;
    ref_err       = 1'b0;
    ref_pending   = 1'b0;
    ref_streaming = 1'b0;
  endfunction

  function automatic void model_write(input int addr, input logic [7:0] d);
    if (addr >= DEPTH || (!DBUF && ref_streaming)) begin
      ref_err = 1'b1;
    end else begin
      ref_mem[DBUF ? 1 - ref_act : ref_act][addr] = d;
      if (!DBUF) ref_ready = 1'b0;
    end
  endfunction

  function automatic void model_commit();
    ref_ready = 1'b1;
    if (DBUF) begin
      if (ref_streaming) ref_pending = 1'b1;
      else               ref_act = 1 - ref_act;
    end
  endfunction

  task automatic do_write(input int addr, input logic [7:0] d);
    kif.i_wr_en   = 1'b1;
    kif.i_wr_addr = addr[4:0];
    kif.i_wr_data = d;
    tick();
    kif.i_wr_en   = 1'b0;
    model_write(addr, d);
  endtask

  task automatic do_commit();
    kif.i_load_done = 1'b1;
    tick();
    kif.i_load_done = 1'b0;
    model_commit();
    check_eq("commit_ready", {31'd0, kif.o_kernel_ready}, {31'd0, ref_ready});
  endtask

  task automatic do_err_clr();
    kif.i_err_clr = 1'b1;
    tick();
    kif.i_err_clr = 1'b0;
    ref_err = 1'b0;
    check_eq("err_clr", {31'd0, kif.o_wr_err}, 32'd0);
  endtask

  task automatic expect_no_stream(input int size, input string tag);
    kif.i_kernel_size = size[5:0];
    kif.i_rd_start    = 1'b1;
    tick();
    kif.i_rd_start    = 1'b0;
    check_eq({tag, "_valid"}, {31'd0, kif.o_rd_valid}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, kif.o_busy}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, kif.o_wr_err}, {31'd0, ref_err});
  endtask

  // ready_mode: 0 always ready, 1 alternating, 2 random; inject adds a write + commit mid-stream
  task automatic run_stream(input int size, input int ready_mode, input bit inject, input string tag);
    logic [7:0] exp_w [DEPTH];
    int beat;
    int cyc;
    bit rdy;
    for (int i = 0; i < DEPTH; i++) exp_w[i] = ref_mem[ref_act][i];
    kif.i_kernel_size = size[5:0];
    kif.i_rd_ready    = 1'b0;
    kif.i_rd_start    = 1'b1;
    tick();
    kif.i_rd_start    = 1'b0;
    ref_streaming     = 1'b1;
    check_eq({tag, "_first_valid"}, {31'd0, kif.o_rd_valid}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, kif.o_busy}, 32'd1);
    beat = 0;
    cyc  = 0;
    while (beat < size && cyc < 400) begin
      kif.i_kernel_size = 6'($urandom_range(0, 63));
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      kif.i_rd_ready = rdy;
      if (inject && cyc == 3) begin
        kif.i_wr_en     = 1'b1;
        kif.i_wr_addr   = 5'd3;
        kif.i_wr_data   = 8'hEE;
        kif.i_load_done = 1'b1;
      end
      check_eq({tag, "_valid"}, {31'd0, kif.o_rd_valid}, 32'd1);
      check_eq({tag, "_addr"}, {27'd0, kif.o_rd_addr}, beat);
      check_eq({tag, "_data"}, {24'd0, kif.o_rd_data}, {24'd0, exp_w[beat]});
      check_eq({tag, "_last"}, {31'd0, kif.o_rd_last}, {31'd0, (beat == size - 1)});
      tick();
      if (inject && cyc == 3) begin
        kif.i_wr_en     = 1'b0;
        kif.i_load_done = 1'b0;
        model_write(3, 8'hEE);
        model_commit();
      end
      if (rdy) beat++;
      cyc++;
    end
    kif.i_rd_ready = 1'b0;
    ref_streaming  = 1'b0;
    if (ref_pending) begin
      ref_act     = 1 - ref_act;
      ref_pending = 1'b0;
    end
    check_eq({tag, "_beats"}, beat, size);
    check_eq({tag, "_end_valid"}, {31'd0, kif.o_rd_valid}, 32'd0);
    check_eq({tag, "_end_busy"}, {31'd0, kif.o_busy}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, kif.o_wr_err}, {31'd0, ref_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sz;
    int nwr;
    int a;
    kif.i_wr_en       = 1'b0;
    kif.i_wr_addr     = '0;
    kif.i_wr_data     = '0;
    kif.i_load_done   = 1'b0;
    kif.i_kernel_size = 6'd0;
    kif.i_rd_start    = 1'b0;
    kif.i_rd_ready    = 1'b0;
    kif.i_err_clr     = 1'b0;
    model_reset();

    #2;
    check_eq("rst_valid", {31'd0, kif.o_rd_valid}, 32'd0);
    check_eq("rst_last", {31'd0, kif.o_rd_last}, 32'd0);
    check_eq("rst_ready", {31'd0, kif.o_kernel_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, kif.o_busy}, 32'd0);
    check_eq("rst_err", {31'd0, kif.o_wr_err}, 32'd0);
    check_eq("rst_addr", {27'd0, kif.o_rd_addr}, 32'd0);
    check_eq("rst_data", {24'd0, kif.o_rd_data}, 32'd0);
    #10 i_rst_n = 1'b1;
    tick();

    expect_no_stream(9, "start_unloaded");

    for (int i = 0; i < 9; i++) do_write(i, 8'(i + 1));
    do_commit();
    run_stream(9, 0, 1'b0, "t1");
    run_stream(9, 1, 1'b0, "t2");
    expect_no_stream(0, "size0");
    expect_no_stream(26, "size26");

    do_write(25, 8'h55);
    check_eq("bad_addr_err", {31'd0, kif.o_wr_err}, {31'd0, ref_err});
    check_eq("bad_addr_ready", {31'd0, kif.o_kernel_ready}, {31'd0, ref_ready});
    run_stream(9, 0, 1'b0, "t3");
    do_err_clr();
    kif.i_err_clr = 1'b1;
    do_write(31, 8'h66);
    kif.i_err_clr = 1'b0;
    check_eq("set_over_clr", {31'd0, kif.o_wr_err}, 32'd1);
    do_err_clr();

    do_write(4, 8'h44);
    check_eq("idle_write_ready", {31'd0, kif.o_kernel_ready}, {31'd0, ref_ready});
    do_commit();

    run_stream(9, 0, 1'b1, "t5");
    run_stream(9, 0, 1'b0, "t5b");
    do_err_clr();

    for (int it = 0; it < 6; it++) begin
      nwr = $urandom_range(4, 30);
      for (int w = 0; w < nwr; w++) begin
        a = $urandom_range(0, 31);
        if (a >= DEPTH && ($urandom_range(0, 3) != 0)) a = a - DEPTH;
        do_write(a, 8'($urandom_range(0, 255)));
      end
      do_commit();
      if (it == 0)      sz = 1;
      else if (it == 1) sz = DEPTH;
      else              sz = $urandom_range(1, DEPTH);
      run_stream(sz, 2, 1'b0, "rnd");
      run_stream(sz, 0, 1'b0, "rnd_b2b");
      do_err_clr();
    end

    kif.i_kernel_size = 6'd9;
    kif.i_rd_ready    = 1'b1;
    kif.i_rd_start    = 1'b1;
    tick();
    kif.i_rd_start    = 1'b0;
    repeat (4) tick();
    check_eq("t6_pre_addr", {27'd0, kif.o_rd_addr}, 32'd4);
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("t6_valid", {31'd0, kif.o_rd_valid}, 32'd0);
    check_eq("t6_busy", {31'd0, kif.o_busy}, 32'd0);
    check_eq("t6_ready", {31'd0, kif.o_kernel_ready}, 32'd0);
    check_eq("t6_data", {24'd0, kif.o_rd_data}, 32'd0);
    #3 i_rst_n = 1'b1;
    kif.i_rd_ready = 1'b0;
    tick();
    expect_no_stream(9, "t6_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
